centroid_tracker: RTL and testbench
===================================

Name: centroid_tracker

Overview:
- Per-frame controller that generates the crosshair coordinates `center_h`/`center_v` consumed by the overlay renderer. These coordinates drive the red tracking lines.
- Accumulates the count and coordinate sums of all active pixels with `Binary_in`=1.
- At frame end, computes the centroid with a sequential divider, then publishes it atomically.
- Applies minimum-area gating and lost-target fallback. Sits in the pixel clock domain beside the VTC and the renderer.

Parameters:
- H_ACT, 640, active pixels per line
- V_ACT, 480, active lines per frame
- CNT_W, 20, pixel-count accumulator width (must hold H_ACT*V_ACT)
- SUM_W, 30, coordinate-sum accumulator width (must hold H_ACT*V_ACT*(H_ACT-1))
- MIN_PIX, 64, minimum set-pixel count for a valid detection
- LOST_FRAMES, 8, consecutive invalid frames before center resets to default

Ports:
- PClk  in  1  pixel clock; all logic rising-edge
- Rst  in  1  synchronous, active-high reset
- VtcDe  in  1  active-video enable from VTC
- VtcHCnt  in  12  horizontal active-pixel coordinate
- VtcVCnt  in  12  vertical active-line coordinate
- Binary_in  in  1  segmentation result for current pixel
- center_h  out  12  published centroid column
- center_v  out  12  published centroid row
- center_valid  out  1  1 = last completed frame produced a valid centroid
- target_lost  out  1  1 = LOST_FRAMES consecutive invalid frames
- frame_done  out  1  one-cycle pulse when new outputs are published
- overrun  out  1  sticky: frame end arrived while divider busy

Behaviour:
- Reset is synchronous and active-high on PClk; it applies immediately, including mid-division.
  - `center_h`=H_ACT/2, `center_v`=V_ACT/2
  - `center_valid`=0, `target_lost`=0, `frame_done`=0, `overrun`=0
  - accumulators, lost counter and FSM return to IDLE.
- Frame start is VtcDe=1 with VtcHCnt=0 and VtcVCnt=0.
  - The accumulators load that pixel's contribution; prior contents are discarded.
- Frame end is VtcDe=1 with VtcHCnt=H_ACT-1 and VtcVCnt=V_ACT-1.
  - The pixel at frame end is included in the snapshot.
- Accumulation on each VtcDe=1 cycle with `Binary_in`=1:
  - cnt += 1
  - sum_h += VtcHCnt
  - sum_v += VtcVCnt
- Accumulators saturate at all-ones; they do not wrap.
- FSM states:
  - IDLE
    - On frame end: copy cnt/sum_h/sum_v (including the current pixel) into snapshot registers.
    - If snapshot cnt < MIN_PIX (including 0): go to REJECT.
    - Otherwise go to DIV_H.
  - DIV_H
    - Restoring long division sum_h / cnt, one quotient bit per cycle, MSB first.
    - Exactly SUM_W cycles.
    - Quotient low 12 bits go to the h result; the quotient is always < H_ACT by construction.
    - Then go to DIV_V.
  - DIV_V
    - Same division for sum_v, SUM_W cycles.
    - Then go to UPDATE.
  - UPDATE (1 cycle)
    - Load `center_h`/`center_v` from the results together (never split across cycles).
    - Set `center_valid`=1, lost counter=0, `target_lost`=0, pulse `frame_done`.
    - Go to IDLE.
  - REJECT (1 cycle)
    - Set `center_valid`=0; lost counter increments, saturating at LOST_FRAMES.
    - When the counter reaches LOST_FRAMES:
      - `target_lost`=1
      - `center_h`/`center_v` return to H_ACT/2, V_ACT/2.
    - Otherwise `center_h`/`center_v` hold their previous values.
    - Pulse `frame_done`; go to IDLE.
- Latency from the frame-end pixel to `frame_done`:
  - valid frame: 2*SUM_W+2 cycles (IDLE capture + divisions + UPDATE)
  - rejected frame: 2 cycles
- A frame end while FSM ≠ IDLE:
  - that frame's snapshot is dropped; `overrun` is set (sticky until Rst)
  - the current computation continues unaffected
  - accumulators still restart at the next frame start.
- Outputs are registered and change only in UPDATE/REJECT/reset. The renderer therefore never sees a partially updated center.
- VtcHCnt/VtcVCnt are ignored when VtcDe=0.

Test Plan:
- Reset, then 3 all-zero frames → `frame_done` pulses 3 times, `center_valid`=0, `center`=(320,240), `target_lost`=0, lost counter=3.
- 10×10 set block at columns 100–109, rows 50–59 → after 62 cycles (SUM_W=30): `center`=(104,54), `center_valid`=1, `frame_done` one cycle.
- Valid frame, then 8 frames with 40 set pixels (<MIN_PIX):
  - frames 1–7: `center` holds the previous value, `center_valid`=0
  - frame 8: `target_lost`=1, `center`=(320,240)
  - next valid frame clears `target_lost`.
- Single set pixel only at (639,479) with MIN_PIX=1 → `center`=(639,479); verifies the last-pixel inclusion and the frame-end coincidence.
- Shortened frame (H_ACT=8, V_ACT=4) with back-to-back frames inside the divider window → `overrun`=1, first frame's result published correctly, dropped frame produces no `frame_done`.
- Assert Rst during DIV_V → next cycle all outputs at reset values, FSM IDLE, no `frame_done`; next frame processes normally.

Source files
------------

// File: rtl/centroid_tracker.sv
// Per-frame centroid tracker. Accumulates set-pixel count and coordinate sums
// over a frame, divides them sequentially after frame end, and publishes the
// crosshair center atomically with minimum-area gating and lost-target fallback.
module centroid_tracker #(
  parameter int unsigned H_ACT       = 640,
  parameter int unsigned V_ACT       = 480,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned SUM_W       = 30,
  parameter int unsigned MIN_PIX     = 64,
  parameter int unsigned LOST_FRAMES = 8
) (
  input  logic        PClk,
  input  logic        Rst,
  input  logic        VtcDe,
  input  logic [11:0] VtcHCnt,
  input  logic [11:0] VtcVCnt,
  input  logic        Binary_in,
  output logic [11:0] center_h,
  output logic [11:0] center_v,
  output logic        center_valid,
  output logic        target_lost,
  output logic        frame_done,
  output logic        overrun
);

  localparam int unsigned BitW  = (SUM_W > 1) ? $clog2(SUM_W) : 1;
  localparam int unsigned LostW = $clog2(LOST_FRAMES + 1);
  localparam logic [11:0] DefH  = 12'(H_ACT / 2);
  localparam logic [11:0] DefV  = 12'(V_ACT / 2);

  typedef enum logic [2:0] {StIdle, StDivH, StDivV, StUpdate, StReject} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] sum_h_q, sum_h_d;
  logic [SUM_W-1:0] sum_v_q, sum_v_d;
  logic [CNT_W-1:0] dvs_q, dvs_d;        // divisor: snapshot pixel count
  logic [SUM_W-1:0] snap_v_q, snap_v_d;  // sum_v waits here while sum_h divides
  logic [SUM_W-1:0] dvd_q, dvd_d;        // dividend shifts out, quotient shifts in
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [11:0]      res_h_q, res_h_d;
  logic [11:0]      res_v_q, res_v_d;
  logic [LostW-1:0] lost_q, lost_d;
  logic [11:0]      center_h_q, center_h_d;
  logic [11:0]      center_v_q, center_v_d;
  logic             center_valid_q, center_valid_d;
  logic             target_lost_q, target_lost_d;
  logic             frame_done_q, frame_done_d;
  logic             overrun_q, overrun_d;

  logic             frame_start, frame_end, pix_set;
  logic [CNT_W-1:0] cnt_base;
  logic [SUM_W-1:0] sum_h_base, sum_v_base;
  logic [CNT_W:0]   cnt_sum;
  logic [SUM_W:0]   sum_h_sum, sum_v_sum;
  logic [CNT_W:0]   rem_sh;
  logic             q_bit;
  logic [SUM_W-1:0] quo_next;
  logic [CNT_W-1:0] rem_next;
  logic [LostW-1:0] lost_inc;

  assign frame_start = VtcDe && (VtcHCnt == 12'd0) && (VtcVCnt == 12'd0);
  assign frame_end   = VtcDe && (VtcHCnt == 12'(H_ACT - 1)) && (VtcVCnt == 12'(V_ACT - 1));
  assign pix_set     = VtcDe && Binary_in;

  // Accumulators: restart on frame start, then saturating add of the current pixel.
  always_comb begin
    cnt_base   = frame_start ? '0 : cnt_q;
    sum_h_base = frame_start ? '0 : sum_h_q;
    sum_v_base = frame_start ? '0 : sum_v_q;
    cnt_sum    = {1'b0, cnt_base} + (CNT_W + 1)'(pix_set);
    sum_h_sum  = {1'b0, sum_h_base} + (SUM_W + 1)'(pix_set ? VtcHCnt : 12'd0);
    sum_v_sum  = {1'b0, sum_v_base} + (SUM_W + 1)'(pix_set ? VtcVCnt : 12'd0);
    cnt_d      = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    sum_h_d    = sum_h_sum[SUM_W] ? '1 : sum_h_sum[SUM_W-1:0];
    sum_v_d    = sum_v_sum[SUM_W] ? '1 : sum_v_sum[SUM_W-1:0];
  end

  // One restoring-division step: bring down the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh   = {rem_q, dvd_q[SUM_W-1]};
    q_bit    = (rem_sh >= {1'b0, dvs_q});
    rem_next = q_bit ? CNT_W'(rem_sh - {1'b0, dvs_q}) : rem_sh[CNT_W-1:0];
    quo_next = {dvd_q[SUM_W-2:0], q_bit};
  end

  assign lost_inc = (lost_q < LostW'(LOST_FRAMES)) ? lost_q + 1'b1 : lost_q;

  // Controller next state: capture, divide h then v, then publish or reject.
  always_comb begin
    state_d        = state_q;
    dvs_d          = dvs_q;
    snap_v_d       = snap_v_q;
    dvd_d          = dvd_q;
    rem_d          = rem_q;
    bit_d          = bit_q;
    res_h_d        = res_h_q;
    res_v_d        = res_v_q;
    lost_d         = lost_q;
    center_h_d     = center_h_q;
    center_v_d     = center_v_q;
    center_valid_d = center_valid_q;
    target_lost_d  = target_lost_q;
    frame_done_d   = 1'b0;
    // A frame end outside IDLE drops that frame's snapshot.
    overrun_d      = overrun_q | (frame_end && (state_q != StIdle));

    case (state_q)
      StIdle: begin
        if (frame_end) begin
          dvs_d    = cnt_d;
          dvd_d    = sum_h_d;
          snap_v_d = sum_v_d;
          rem_d    = '0;
          bit_d    = '0;
          state_d  = (cnt_d < CNT_W'(MIN_PIX)) ? StReject : StDivH;
        end
      end
      StDivH: begin
        dvd_d = quo_next;
        rem_d = rem_next;
        bit_d = bit_q + 1'b1;
        if (bit_q == BitW'(SUM_W - 1)) begin
          res_h_d = quo_next[11:0];
          dvd_d   = snap_v_q;
          rem_d   = '0;
          bit_d   = '0;
          state_d = StDivV;
        end
      end
      StDivV: begin
        dvd_d = quo_next;
        rem_d = rem_next;
        bit_d = bit_q + 1'b1;
        if (bit_q == BitW'(SUM_W - 1)) begin
          res_v_d = quo_next[11:0];
          bit_d   = '0;
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        center_h_d     = res_h_q;
        center_v_d     = res_v_q;
        center_valid_d = 1'b1;
        lost_d         = '0;
        target_lost_d  = 1'b0;
        frame_done_d   = 1'b1;
        state_d        = StIdle;
      end
      StReject: begin
        center_valid_d = 1'b0;
        lost_d         = lost_inc;
        if (lost_inc == LostW'(LOST_FRAMES)) begin
          target_lost_d = 1'b1;
          center_h_d    = DefH;
          center_v_d    = DefV;
        end
        frame_done_d = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge PClk) begin
    if (Rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      sum_h_q        <= '0;
      sum_v_q        <= '0;
      dvs_q          <= '0;
      snap_v_q       <= '0;
      dvd_q          <= '0;
      rem_q          <= '0;
      bit_q          <= '0;
      res_h_q        <= '0;
      res_v_q        <= '0;
      lost_q         <= '0;
      center_h_q     <= DefH;
      center_v_q     <= DefV;
      center_valid_q <= 1'b0;
      target_lost_q  <= 1'b0;
      frame_done_q   <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sum_h_q        <= sum_h_d;
      sum_v_q        <= sum_v_d;
      dvs_q          <= dvs_d;
      snap_v_q       <= snap_v_d;
      dvd_q          <= dvd_d;
      rem_q          <= rem_d;
      bit_q          <= bit_d;
      res_h_q        <= res_h_d;
      res_v_q        <= res_v_d;
      lost_q         <= lost_d;
      center_h_q     <= center_h_d;
      center_v_q     <= center_v_d;
      center_valid_q <= center_valid_d;
      target_lost_q  <= target_lost_d;
      frame_done_q   <= frame_done_d;
      overrun_q      <= overrun_d;
    end
  end

  assign center_h     = center_h_q;
  assign center_v     = center_v_q;
  assign center_valid = center_valid_q;
  assign target_lost  = target_lost_q;
  assign frame_done   = frame_done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_centroid_tracker.sv
// Scoreboard bench for centroid_tracker: sparse randomized frames, expected
// publications computed from the set-pixel lists and queued; a negedge monitor
// pops and compares on every frame_done and checks that outputs hold otherwise.
`timescale 1ns/1ps
module tb_centroid_tracker;

  localparam int unsigned H_ACT       = 640;
  localparam int unsigned V_ACT       = 480;
  localparam int unsigned CNT_W       = 20;
  localparam int unsigned SUM_W       = 30;
  localparam int unsigned MIN_PIX     = 64;
  localparam int unsigned LOST_FRAMES = 8;
  localparam int          LAT_VALID   = 2 * SUM_W + 2;
  localparam int          LAT_REJECT  = 2;
  localparam logic [11:0] DEF_H       = 12'(H_ACT / 2);
  localparam logic [11:0] DEF_V       = 12'(V_ACT / 2);

  logic        clk = 1'b0;
  logic        rst, de, bin;
  logic [11:0] hc, vc;
  logic [11:0] center_h, center_v;
  logic        center_valid, target_lost, frame_done, overrun;

  centroid_tracker #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .CNT_W(CNT_W), .SUM_W(SUM_W),
    .MIN_PIX(MIN_PIX), .LOST_FRAMES(LOST_FRAMES)
  ) dut (
    .PClk(clk), .Rst(rst), .VtcDe(de), .VtcHCnt(hc), .VtcVCnt(vc), .Binary_in(bin),
    .center_h(center_h), .center_v(center_v), .center_valid(center_valid),
    .target_lost(target_lost), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { int h; int v; } pt_t;
  typedef struct {
    logic [11:0] h;
    logic [11:0] v;
    logic        valid;
    logic        lost;
    longint      due;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  longint      cyc = 0;
  longint      busy_until = 0;
  int          m_lost;
  logic [11:0] m_h, m_v;
  logic        m_tl, m_ovr;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic d, input int h, input int v, input logic b);
    de = d; hc = 12'(h); vc = 12'(v); bin = b;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic pt_t rand_pt();
    pt_t p;
    do begin
      p.h = int'($urandom_range(H_ACT - 1));
      p.v = int'($urandom_range(V_ACT - 1));
    end while ((p.h == 0 && p.v == 0) || (p.h == H_ACT - 1 && p.v == V_ACT - 1));
    return p;
  endfunction

  // De-asserted cycles; coordinates (even the frame-end one) must be ignored.
  task automatic idle(input int n);
    pt_t p;
    for (int i = 0; i < n; i++) begin
      p = rand_pt();
      if ($urandom_range(7) == 0) step(1'b0, H_ACT - 1, V_ACT - 1, 1'b1);
      else step(1'b0, p.h, p.v, 1'($urandom_range(1)));
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_lost = 0; m_h = DEF_H; m_v = DEF_V; m_tl = 1'b0; m_ovr = 1'b0;
    busy_until = cyc;
  endtask

  // Reference: centroid = mean of set coordinates when the frame is accepted.
  task automatic score_frame(input int cnt, input longint sh, input longint sv);
    exp_t e;
    if (cyc < busy_until) begin
      m_ovr = 1'b1;
      return;
    end
    if (cnt >= int'(MIN_PIX)) begin
      m_h = 12'(sh / cnt); m_v = 12'(sv / cnt);
      m_lost = 0; m_tl = 1'b0; e.valid = 1'b1;
      busy_until = cyc + LAT_VALID;
    end else begin
      if (m_lost < int'(LOST_FRAMES)) m_lost++;
      if (m_lost == int'(LOST_FRAMES)) begin
        m_tl = 1'b1; m_h = DEF_H; m_v = DEF_V;
      end
      e.valid = 1'b0;
      busy_until = cyc + LAT_REJECT;
    end
    e.h = m_h; e.v = m_v; e.lost = m_tl; e.due = busy_until - 1;
    sb.push_back(e);
  endtask

  // Junk set pixels, frame start, listed set pixels mixed with gaps and clear
  // pixels, then the frame-end pixel.
  task automatic run_frame(input pt_t pts[$], input bit b0, input bit bend, input int junk);
    pt_t    p;
    int     cnt;
    longint sh, sv;
    for (int i = 0; i < junk; i++) begin
      p = rand_pt();
      step(1'b1, p.h, p.v, 1'b1);
    end
    step(1'b1, 0, 0, b0);
    foreach (pts[i]) begin
      if ($urandom_range(3) == 0) idle(1);
      if ($urandom_range(3) == 0) begin
        p = rand_pt();
        step(1'b1, p.h, p.v, 1'b0);
      end
      step(1'b1, pts[i].h, pts[i].v, 1'b1);
    end
    step(1'b1, H_ACT - 1, V_ACT - 1, bend);
    cnt = pts.size() + int'(b0) + int'(bend);
    sh  = bend ? longint'(H_ACT - 1) : 0;
    sv  = bend ? longint'(V_ACT - 1) : 0;
    foreach (pts[i]) begin
      sh += pts[i].h;
      sv += pts[i].v;
    end
    score_frame(cnt, sh, sv);
  endtask

  task automatic wait_quiet();
    while (cyc < busy_until) idle(1);
    idle(2);
  endtask

  task automatic rand_pts(output pt_t pts[$], input int n);
    pts.delete();
    for (int i = 0; i < n; i++) pts.push_back(rand_pt());
  endtask

  task automatic check_reset_values();
    check("rst_center_h", center_h, DEF_H);
    check("rst_center_v", center_v, DEF_V);
    check("rst_center_valid", center_valid, 0);
    check("rst_target_lost", target_lost, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
  endtask

  // Monitor: pop on frame_done, otherwise published outputs must hold.
  logic [11:0] mon_h = DEF_H, mon_v = DEF_V;
  logic        mon_valid = 1'b0, mon_tl = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      mon_h <= DEF_H; mon_v <= DEF_V; mon_valid <= 1'b0; mon_tl <= 1'b0;
    end else begin
      if (frame_done) begin
        if (sb.size() == 0) begin
          check("unexpected_frame_done", frame_done, 0);
        end else begin
          check("done_center_h", center_h, sb[0].h);
          check("done_center_v", center_v, sb[0].v);
          check("done_center_valid", center_valid, sb[0].valid);
          check("done_target_lost", target_lost, sb[0].lost);
          check("done_latency_cycle", cyc, sb[0].due);
          mon_h <= sb[0].h; mon_v <= sb[0].v;
          mon_valid <= sb[0].valid; mon_tl <= sb[0].lost;
          sb.delete(0);
        end
      end else begin
        check("hold_center_h", center_h, mon_h);
        check("hold_center_v", center_v, mon_v);
        check("hold_center_valid", center_valid, mon_valid);
        check("hold_target_lost", target_lost, mon_tl);
      end
      check("overrun_flag", overrun, m_ovr);
    end
  end

  initial begin
    pt_t pts[$];
    rst = 1'b1; de = 1'b0; hc = '0; vc = '0; bin = 1'b0;
    model_reset();
    idle(3);
    rst = 1'b0;
    model_reset();
    check_reset_values();

    // Three empty frames: rejected, center stays at default.
    for (int f = 0; f < 3; f++) begin
      pts.delete();
      run_frame(pts, 1'b0, 1'b0, int'($urandom_range(3)));
      idle(3);
    end
    wait_quiet();
    check("empty_center_h", center_h, DEF_H);
    check("empty_target_lost", target_lost, 0);

    // 10x10 block at columns 100..109, rows 50..59.
    pts.delete();
    for (int v = 50; v < 60; v++)
      for (int h = 100; h < 110; h++) pts.push_back('{h: h, v: v});
    run_frame(pts, 1'b0, 1'b0, 2);
    wait_quiet();
    check("block_center_h", center_h, 104);
    check("block_center_v", center_v, 54);
    check("block_center_valid", center_valid, 1);

    // Eight under-sized frames: hold for seven, fall back on the eighth.
    for (int f = 1; f <= int'(LOST_FRAMES); f++) begin
      rand_pts(pts, 40);
      run_frame(pts, 1'b0, 1'b0, 1);
      wait_quiet();
      if (f < int'(LOST_FRAMES)) check("lost_hold_h", center_h, 104);
    end
    check("lost_target_lost", target_lost, 1);
    check("lost_center_v", center_v, DEF_V);
    rand_pts(pts, 100);
    run_frame(pts, 1'b1, 1'b0, 0);
    wait_quiet();
    check("recover_target_lost", target_lost, 0);

    // Count boundary: the frame-end pixel completes exactly MIN_PIX.
    rand_pts(pts, int'(MIN_PIX) - 1);
    run_frame(pts, 1'b0, 1'b1, 0);
    wait_quiet();
    check("edge_minpix_valid", center_valid, 1);
    rand_pts(pts, int'(MIN_PIX) - 2);
    run_frame(pts, 1'b0, 1'b1, 0);
    wait_quiet();
    check("edge_below_minpix_valid", center_valid, 0);
    run_frame(pts, 1'b1, 1'b1, 0);
    wait_quiet();
    check("edge_start_pixel_valid", center_valid, 1);

    // Back-to-back frame inside the divider window is dropped.
    rand_pts(pts, 80);
    run_frame(pts, 1'b0, 1'b0, 0);
    pts.delete();
    run_frame(pts, 1'b0, 1'b0, 0);
    wait_quiet();
    check("overrun_set", overrun, 1);

    // Randomized frames, occasionally issued before the previous one finishes.
    for (int f = 0; f < 25; f++) begin
      rand_pts(pts, int'($urandom_range(160)));
      run_frame(pts, 1'($urandom_range(1)), 1'($urandom_range(1)),
                int'($urandom_range(4)));
      if ($urandom_range(5) == 0) idle(1);
      else wait_quiet();
    end
    wait_quiet();

    // Reset in the middle of the second division.
    rand_pts(pts, 120);
    run_frame(pts, 1'b0, 1'b0, 0);
    idle(40);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    model_reset();
    check_reset_values();
    idle(80);
    rand_pts(pts, 90);
    run_frame(pts, 1'b0, 1'b0, 0);
    wait_quiet();
    check("post_reset_valid", center_valid, 1);

    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
